// File: rtl/asa_noc_enc_pkg.sv
// Shared ASA definitions: request/response messages, opcodes, and the
// packet geometry used by the NoC response encoder.
package asa_noc_enc_pkg;

    // ASA instruction opcodes
    localparam logic [3:0] ASA_GET  = 4'h0;
    localparam logic [3:0] ASA_PUT  = 4'h1;
    localparam logic [3:0] ASA_DEL  = 4'h2;
    localparam logic [3:0] ASA_ACK  = 4'h8;
    localparam logic [3:0] ASA_NACK = 4'h9;

    // NoC size code: payload is 2^size words
    localparam int ASA_SIZE_CODE = 3;
    localparam int ASA_PAY_BEATS = 1 << ASA_SIZE_CODE;
    localparam int ASA_CNT_W     = ASA_SIZE_CODE;
    localparam logic [ASA_CNT_W-1:0] ASA_LAST_BEAT = ASA_CNT_W'(ASA_PAY_BEATS - 1);

    localparam logic [3:0] ASA_KEEP_ALL  = 4'hF;
    localparam logic [3:0] ASA_KEEP_NONE = 4'h0;

    typedef struct packed {
        logic [3:0]  inst;
        logic [31:0] key;
        logic [63:0] data;
    } ASAReqMsg;

    typedef struct packed {
        logic [3:0]  inst;
        logic [31:0] key;
        logic [63:0] data;
    } ASARespMsg;

    typedef enum logic [1:0] {
        ENC_IDLE = 2'd0,
        ENC_HDR  = 2'd1,
        ENC_PAY  = 2'd2
    } asa_enc_state_e;

    // Payload word selected by the beat counter; words past the message are zero pad.
    function automatic logic [31:0] asa_pay_word(input ASARespMsg msg,
                                                 input logic [ASA_CNT_W-1:0] idx);
        logic [31:0] word_s;
        case (idx)
            3'd0:    word_s = {28'h0000000, msg.inst};
            3'd1:    word_s = msg.key;
            3'd2:    word_s = msg.data[63:32];
            3'd3:    word_s = msg.data[31:0];
            default: word_s = 32'h0000_0000;
        endcase
        return word_s;
    endfunction

endpackage

// File: rtl/asa_noc_enc_hdr_fifo.sv
// Small circular queue holding pre-built NoC response headers until the
// matching ASA response shows up. A push while full is dropped unless a
// pop happens in the same cycle, in which case the slot is reused.
module asa_hdr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic             nonempty_next
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == '0);
    assign pop_data  = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign nonempty_next = (count_next_s != '0);

    // Occupancy for the next cycle; push+pop together leave it unchanged.
    always_comb begin
        if (push_ok_s && !pop_ok_s) begin
            count_next_s = count_r + CW'(1);
        end else if (!push_ok_s && pop_ok_s) begin
            count_next_s = count_r - CW'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointer, occupancy and storage update; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            count_r <= count_next_s;
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

endmodule

// File: rtl/asa_noc_enc.sv
// ASA response -> NoC AXI-Stream encoder. Pairs each queued response
// header with the next ASA response and emits a 9-beat packet:
// header, inst, key, data hi, data lo, then zero pad to 8 payload words.
module asa_noc_enc
    import asa_noc_enc_pkg::*;
#(
    parameter int HDR_DEPTH = 2
) (
    input  logic        clk_ctrl,
    input  logic        clk_ctrl_rst_low,
    input  logic        header_in_vld,
    input  logic [31:0] header_in,
    input  logic        resp_val,
    input  ASARespMsg   resp_msg,
    output logic        resp_rdy,
    output logic        stream_out_TVALID,
    output logic [31:0] stream_out_TDATA,
    output logic [3:0]  stream_out_TKEEP,
    output logic        stream_out_TLAST,
    input  logic        stream_out_TREADY,
    output logic        hdr_overflow
);

    asa_enc_state_e       state_r;
    asa_enc_state_e       state_next_s;
    logic [ASA_CNT_W-1:0] cnt_r;
    logic [ASA_CNT_W-1:0] cnt_next_s;
    logic [ASA_CNT_W-1:0] cnt_inc_s;
    ASARespMsg            msg_r;
    ASARespMsg            msg_next_s;
    logic                 tvalid_r;
    logic                 tvalid_next_s;
    logic [31:0]          tdata_r;
    logic [31:0]          tdata_next_s;
    logic [3:0]           tkeep_r;
    logic [3:0]           tkeep_next_s;
    logic                 tlast_r;
    logic                 tlast_next_s;
    logic                 resp_rdy_r;
    logic                 resp_rdy_next_s;
    logic                 hdr_overflow_r;

    logic [31:0]          fifo_head_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 fifo_nonempty_next_s;
    logic                 fifo_pop_s;
    logic                 hdr_drop_s;
    logic                 beat_done_s;

    asa_hdr_fifo #(
        .DEPTH (HDR_DEPTH),
        .WIDTH (32)
    ) u_hdr_fifo (
        .clk           (clk_ctrl),
        .rst_n         (clk_ctrl_rst_low),
        .push          (header_in_vld),
        .push_data     (header_in),
        .pop           (fifo_pop_s),
        .pop_data      (fifo_head_s),
        .full          (fifo_full_s),
        .empty         (fifo_empty_s),
        .nonempty_next (fifo_nonempty_next_s)
    );

    assign beat_done_s = tvalid_r && stream_out_TREADY;
    assign cnt_inc_s   = cnt_r + ASA_CNT_W'(1);
    assign hdr_drop_s  = header_in_vld && fifo_full_s && !fifo_pop_s;

    // Next-state and next-beat selection; every register holds unless a beat or accept occurs.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        msg_next_s    = msg_r;
        tvalid_next_s = tvalid_r;
        tdata_next_s  = tdata_r;
        tkeep_next_s  = tkeep_r;
        tlast_next_s  = tlast_r;
        fifo_pop_s    = 1'b0;
        case (state_r)
            ENC_IDLE: begin
                if (resp_val && resp_rdy_r && !fifo_empty_s) begin
                    fifo_pop_s    = 1'b1;
                    msg_next_s    = resp_msg;
                    tvalid_next_s = 1'b1;
                    tdata_next_s  = fifo_head_s;
                    tkeep_next_s  = ASA_KEEP_ALL;
                    tlast_next_s  = 1'b0;
                    cnt_next_s    = '0;
                    state_next_s  = ENC_HDR;
                end else begin
                    tvalid_next_s = 1'b0;
                    tdata_next_s  = 32'h0000_0000;
                    tkeep_next_s  = ASA_KEEP_NONE;
                    tlast_next_s  = 1'b0;
                end
            end
            ENC_HDR: begin
                if (beat_done_s) begin
                    cnt_next_s   = '0;
                    tdata_next_s = asa_pay_word(msg_r, '0);
                    tlast_next_s = 1'b0;
                    state_next_s = ENC_PAY;
                end else begin
                    state_next_s = ENC_HDR;
                end
            end
            ENC_PAY: begin
                if (beat_done_s) begin
                    if (cnt_r == ASA_LAST_BEAT) begin
                        cnt_next_s    = '0;
                        tvalid_next_s = 1'b0;
                        tdata_next_s  = 32'h0000_0000;
                        tkeep_next_s  = ASA_KEEP_NONE;
                        tlast_next_s  = 1'b0;
                        state_next_s  = ENC_IDLE;
                    end else begin
                        cnt_next_s   = cnt_inc_s;
                        tdata_next_s = asa_pay_word(msg_r, cnt_inc_s);
                        tlast_next_s = (cnt_inc_s == ASA_LAST_BEAT);
                    end
                end else begin
                    state_next_s = ENC_PAY;
                end
            end
            default: begin
                cnt_next_s    = '0;
                tvalid_next_s = 1'b0;
                tdata_next_s  = 32'h0000_0000;
                tkeep_next_s  = ASA_KEEP_NONE;
                tlast_next_s  = 1'b0;
                state_next_s  = ENC_IDLE;
            end
        endcase
    end

    // Ready for a response next cycle only when idle with a header waiting.
    always_comb begin
        if (state_next_s == ENC_IDLE) begin
            resp_rdy_next_s = fifo_nonempty_next_s;
        end else begin
            resp_rdy_next_s = 1'b0;
        end
    end

    // FSM state, beat counter, captured message and registered stream outputs.
    always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
        if (!clk_ctrl_rst_low) begin
            state_r    <= ENC_IDLE;
            cnt_r      <= '0;
            msg_r      <= '0;
            tvalid_r   <= 1'b0;
            tdata_r    <= 32'h0000_0000;
            tkeep_r    <= ASA_KEEP_NONE;
            tlast_r    <= 1'b0;
            resp_rdy_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            msg_r      <= msg_next_s;
            tvalid_r   <= tvalid_next_s;
            tdata_r    <= tdata_next_s;
            tkeep_r    <= tkeep_next_s;
            tlast_r    <= tlast_next_s;
            resp_rdy_r <= resp_rdy_next_s;
        end
    end

    // Sticky flag: a header was lost because the queue had no room.
    always_ff @(posedge clk_ctrl or negedge clk_ctrl_rst_low) begin
        if (!clk_ctrl_rst_low) begin
            hdr_overflow_r <= 1'b0;
        end else if (hdr_drop_s) begin
            hdr_overflow_r <= 1'b1;
        end else begin
            hdr_overflow_r <= hdr_overflow_r;
        end
    end

    assign resp_rdy          = resp_rdy_r;
    assign stream_out_TVALID = tvalid_r;
    assign stream_out_TDATA  = tdata_r;
    assign stream_out_TKEEP  = tkeep_r;
    assign stream_out_TLAST  = tlast_r;
    assign hdr_overflow      = hdr_overflow_r;

endmodule

// File: tb/tb_asa_noc_enc.sv
// Scoreboard bench for asa_noc_enc: stimulus queues expected beats,
// a negedge monitor pops and compares every accepted beat.
module tb_asa_noc_enc;
    import asa_noc_enc_pkg::*;

    logic        clk_ctrl;
    logic        clk_ctrl_rst_low;
    logic        header_in_vld;
    logic [31:0] header_in;
    logic        resp_val;
    ASARespMsg   resp_msg;
    logic        resp_rdy;
    logic        stream_out_TVALID;
    logic [31:0] stream_out_TDATA;
    logic [3:0]  stream_out_TKEEP;
    logic        stream_out_TLAST;
    logic        stream_out_TREADY;
    logic        hdr_overflow;

    int          total = 0;
    int          bad = 0;
    int          valid_cyc = 0;
    bit          toggle_mode = 1'b0;
    logic [32:0] exp_q [$];

    asa_noc_enc #(.HDR_DEPTH(2)) dut (
        .clk_ctrl          (clk_ctrl),
        .clk_ctrl_rst_low  (clk_ctrl_rst_low),
        .header_in_vld     (header_in_vld),
        .header_in         (header_in),
        .resp_val          (resp_val),
        .resp_msg          (resp_msg),
        .resp_rdy          (resp_rdy),
        .stream_out_TVALID (stream_out_TVALID),
        .stream_out_TDATA  (stream_out_TDATA),
        .stream_out_TKEEP  (stream_out_TKEEP),
        .stream_out_TLAST  (stream_out_TLAST),
        .stream_out_TREADY (stream_out_TREADY),
        .hdr_overflow      (hdr_overflow)
    );

    initial begin
        clk_ctrl = 1'b0;
        forever #5 clk_ctrl = ~clk_ctrl;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk_ctrl);
        #1;
    endtask

    task automatic exp_packet(input logic [31:0] hdr, input logic [3:0] op,
                              input logic [31:0] k, input logic [63:0] d);
        exp_q.push_back({1'b0, hdr});
        exp_q.push_back({1'b0, 28'h0000000, op});
        exp_q.push_back({1'b0, k});
        exp_q.push_back({1'b0, d[63:32]});
        exp_q.push_back({1'b0, d[31:0]});
        exp_q.push_back({1'b0, 32'h0000_0000});
        exp_q.push_back({1'b0, 32'h0000_0000});
        exp_q.push_back({1'b0, 32'h0000_0000});
        exp_q.push_back({1'b1, 32'h0000_0000});
    endtask

    task automatic push_hdr(input logic [31:0] h);
        header_in_vld = 1'b1;
        header_in     = h;
        tick();
        header_in_vld = 1'b0;
    endtask

    task automatic send_resp(input logic [31:0] hdr, input logic [3:0] op,
                             input logic [31:0] k, input logic [63:0] d);
        int n = 0;
        exp_packet(hdr, op, k, d);
        resp_msg.inst = op;
        resp_msg.key  = k;
        resp_msg.data = d;
        resp_val      = 1'b1;
        while (!resp_rdy && n < 100) begin
            tick();
            n++;
        end
        if (!resp_rdy) begin
            timeout_fail("resp_accept");
        end else begin
            tick();
        end
        resp_val = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || stream_out_TVALID) && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || stream_out_TVALID) timeout_fail(name);
    endtask

    task automatic do_reset();
        header_in_vld    = 1'b0;
        resp_val         = 1'b0;
        clk_ctrl_rst_low = 1'b0;
        exp_q.delete();
        tick();
        tick();
        clk_ctrl_rst_low = 1'b1;
        tick();
    endtask

    // Downstream ready: always ready, or alternating starting ready on the first valid cycle.
    initial begin
        stream_out_TREADY = 1'b1;
        forever begin
            @(posedge clk_ctrl);
            #1;
            if (!toggle_mode) stream_out_TREADY = 1'b1;
            else if (!stream_out_TVALID) stream_out_TREADY = 1'b0;
            else stream_out_TREADY = ~stream_out_TREADY;
        end
    end

    // Monitor: compares accepted beats with the scoreboard and checks stall stability.
    initial begin
        logic        hold_prev;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [32:0] e;
        hold_prev = 1'b0;
        prev_data = 32'h0;
        prev_last = 1'b0;
        forever begin
            @(negedge clk_ctrl);
            if (!clk_ctrl_rst_low) begin
                hold_prev = 1'b0;
            end else if (stream_out_TVALID) begin
                valid_cyc++;
                check("tkeep_valid", {28'h0, stream_out_TKEEP}, 32'h0000_000F);
                if (hold_prev) begin
                    check("stall_data", stream_out_TDATA, prev_data);
                    check("stall_last", {31'h0, stream_out_TLAST}, {31'h0, prev_last});
                end
                if (stream_out_TREADY) begin
                    hold_prev = 1'b0;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat: got %h expected none", stream_out_TDATA);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", stream_out_TDATA, e[31:0]);
                        check("beat_last", {31'h0, stream_out_TLAST}, {31'h0, e[32]});
                    end
                end else begin
                    hold_prev = 1'b1;
                    prev_data = stream_out_TDATA;
                    prev_last = stream_out_TLAST;
                end
            end else begin
                hold_prev = 1'b0;
                check("tkeep_idle", {28'h0, stream_out_TKEEP}, 32'h0000_0000);
                check("tlast_idle", {31'h0, stream_out_TLAST}, 32'h0000_0000);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus sequence.
    initial begin
        clk_ctrl_rst_low = 1'b0;
        header_in_vld    = 1'b0;
        header_in        = 32'h0;
        resp_val         = 1'b0;
        resp_msg         = '0;
        tick();
        check("rst_tvalid", {31'h0, stream_out_TVALID}, 32'h0);
        check("rst_tdata", stream_out_TDATA, 32'h0);
        check("rst_tkeep", {28'h0, stream_out_TKEEP}, 32'h0);
        check("rst_tlast", {31'h0, stream_out_TLAST}, 32'h0);
        check("rst_resp_rdy", {31'h0, resp_rdy}, 32'h0);
        check("rst_overflow", {31'h0, hdr_overflow}, 32'h0);
        tick();
        clk_ctrl_rst_low = 1'b1;
        tick();
        check("empty_resp_rdy", {31'h0, resp_rdy}, 32'h0);

        // Basic packet, always ready.
        valid_cyc = 0;
        push_hdr(32'h1234_5678);
        send_resp(32'h1234_5678, 4'h1, 32'h0000_00AA, 64'h0000_0001_0000_0002);
        wait_idle("pkt_basic");
        check("basic_valid_cycles", valid_cyc, 32'd9);

        // Same packet with alternating ready.
        toggle_mode = 1'b1;
        valid_cyc = 0;
        push_hdr(32'h1234_5678);
        send_resp(32'h1234_5678, 4'h1, 32'h0000_00AA, 64'h0000_0001_0000_0002);
        wait_idle("pkt_toggle");
        check("toggle_valid_cycles", valid_cyc, 32'd17);
        toggle_mode = 1'b0;
        tick();

        // Response waiting with no header must stall.
        exp_packet(32'hCAFE_0001, 4'h2, 32'h0000_BEEF, 64'h0123_4567_89AB_CDEF);
        resp_msg.inst = 4'h2;
        resp_msg.key  = 32'h0000_BEEF;
        resp_msg.data = 64'h0123_4567_89AB_CDEF;
        resp_val = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("stall_no_hdr", {31'h0, resp_rdy}, 32'h0);
            tick();
        end
        push_hdr(32'hCAFE_0001);
        check("rdy_after_hdr", {31'h0, resp_rdy}, 32'h1);
        tick();
        resp_val = 1'b0;
        wait_idle("pkt_stall");

        // Three headers into a two-deep queue: third one dropped.
        header_in_vld = 1'b1;
        header_in = 32'h0000_0011;
        tick();
        header_in = 32'h0000_0022;
        tick();
        header_in = 32'h0000_0033;
        tick();
        header_in_vld = 1'b0;
        check("overflow_set", {31'h0, hdr_overflow}, 32'h1);
        send_resp(32'h0000_0011, 4'h1, 32'h0000_0001, 64'h0000_0000_0000_0011);
        send_resp(32'h0000_0022, 4'h1, 32'h0000_0002, 64'h0000_0000_0000_0022);
        wait_idle("pkt_overflow");
        check("queue_drained", {31'h0, resp_rdy}, 32'h0);
        check("overflow_sticky", {31'h0, hdr_overflow}, 32'h1);

        // Reset in the middle of a packet.
        do_reset();
        check("overflow_cleared", {31'h0, hdr_overflow}, 32'h0);
        push_hdr(32'hDEAD_0004);
        send_resp(32'hDEAD_0004, 4'h3, 32'h0000_0044, 64'h0000_1111_0000_2222);
        begin
            int n = 0;
            while (exp_q.size() != 6 && n < 100) begin
                tick();
                n++;
            end
            if (exp_q.size() != 6) timeout_fail("reach_beat4");
        end
        check("beat4_before_reset", stream_out_TDATA, 32'h0000_1111);
        #1;
        clk_ctrl_rst_low = 1'b0;
        #1;
        check("midrst_tvalid", {31'h0, stream_out_TVALID}, 32'h0);
        check("midrst_tdata", stream_out_TDATA, 32'h0);
        check("midrst_tkeep", {28'h0, stream_out_TKEEP}, 32'h0);
        check("midrst_tlast", {31'h0, stream_out_TLAST}, 32'h0);
        check("midrst_resp_rdy", {31'h0, resp_rdy}, 32'h0);
        exp_q.delete();
        tick();
        tick();
        clk_ctrl_rst_low = 1'b1;
        tick();
        valid_cyc = 0;
        push_hdr(32'h5A5A_0006);
        send_resp(32'h5A5A_0006, 4'h4, 32'h0000_0066, 64'h7777_0000_0000_8888);
        wait_idle("pkt_after_reset");
        check("postrst_valid_cycles", valid_cyc, 32'd9);

        // Push and pop together while full: no overflow, order kept.
        do_reset();
        header_in_vld = 1'b1;
        header_in = 32'h0000_00A1;
        tick();
        header_in = 32'h0000_00A2;
        tick();
        header_in_vld = 1'b0;
        check("full_rdy", {31'h0, resp_rdy}, 32'h1);
        exp_packet(32'h0000_00A1, 4'h5, 32'h0000_0A01, 64'h0000_0000_0000_0A01);
        resp_msg.inst = 4'h5;
        resp_msg.key  = 32'h0000_0A01;
        resp_msg.data = 64'h0000_0000_0000_0A01;
        resp_val = 1'b1;
        header_in_vld = 1'b1;
        header_in = 32'h0000_00A3;
        tick();
        resp_val = 1'b0;
        header_in_vld = 1'b0;
        check("pushpop_no_overflow", {31'h0, hdr_overflow}, 32'h0);
        send_resp(32'h0000_00A2, 4'h6, 32'h0000_0A02, 64'h0000_0000_0000_0A02);
        send_resp(32'h0000_00A3, 4'h7, 32'h0000_0A03, 64'h0000_0000_0000_0A03);
        wait_idle("pkt_pushpop");
        check("pushpop_overflow_end", {31'h0, hdr_overflow}, 32'h0);
        check("pushpop_drained", {31'h0, resp_rdy}, 32'h0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
